// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: register offsets,
// CTRL field positions, segment bit order and the hex-to-segment table.
package seg_pkg;

  localparam int unsigned DIGIT_STRIDE = 4;
  localparam logic [31:0] CTRL_OFFSET  = 32'h0000_0040;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_HEX_BIT    = 1;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_MASK_LSB   = 16;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment patterns for 0..F, bit0 = segment a.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern (active-high, bit0 = a).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]         val_i,
  output logic [SEG_G:SEG_A] seg_o
);

  assign seg_o = HEX_TABLE[val_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped multiplexed seven-segment controller: digit/CTRL registers with
// readback, hex decode, 16-level brightness PWM, per-digit blink, active-low pins.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int          NUM_DIGITS = 6,
  parameter int          CLK        = 50,
  parameter int          SCAN_F     = 400,
  parameter int          BLINK_HZ   = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0010
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  re,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           dataIn,
  output logic [31:0]           dataOut,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_sel
);

  localparam int SCAN_CNT  = CLK * 1000000 / SCAN_F;
  localparam int SUB_CNT   = SCAN_CNT / 16;
  localparam int BLINK_CNT = CLK * 1000000 / (2 * BLINK_HZ);
  localparam int SUB_W     = cnt_width(SUB_CNT);
  localparam int BLINK_W   = cnt_width(BLINK_CNT);
  localparam int IDX_W     = cnt_width(NUM_DIGITS);

  logic [7:0]            digit_q [NUM_DIGITS];
  logic                  en_q, hex_q;
  logic [3:0]            bright_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [31:0]           rd_q, rd_d, ctrl_rd;

  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [3:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_q, blink_d;

  logic [31:0]           offset;
  logic                  aligned, ctrl_hit;
  logic [NUM_DIGITS-1:0] digit_hit;
  logic                  unused_wdata;

  assign offset       = addr - BASE_ADDR;
  assign aligned      = (addr[1:0] == 2'b00);
  assign ctrl_hit     = aligned && (offset == CTRL_OFFSET);
  assign unused_wdata = ^dataIn;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    digit_hit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_hit[i] = aligned && (offset == 32'(DIGIT_STRIDE * i));
    end
  end

  // NOTE: the small digit register file is reset explicitly because its reset
  // contents are architecturally visible on readback and on the display.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      en_q     <= 1'b1;
      hex_q    <= 1'b0;
      bright_q <= 4'hF;
      mask_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (we && digit_hit[i]) digit_q[i] <= dataIn[7:0];
      end
      if (we && ctrl_hit) begin
        en_q     <= dataIn[CTRL_EN_BIT];
        hex_q    <= dataIn[CTRL_HEX_BIT];
        bright_q <= dataIn[CTRL_BRIGHT_LSB +: 4];
        mask_q   <= dataIn[CTRL_MASK_LSB +: NUM_DIGITS];
      end
    end
  end

  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_EN_BIT]                    = en_q;
    ctrl_rd[CTRL_HEX_BIT]                   = hex_q;
    ctrl_rd[CTRL_BRIGHT_LSB +: 4]           = bright_q;
    ctrl_rd[CTRL_MASK_LSB +: NUM_DIGITS]    = mask_q;
  end

  // Read data is taken from pre-write state, so a same-cycle write returns old data.
  always_comb begin
    rd_d = '0;
    if (re) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_hit[i]) rd_d = {24'h0, digit_q[i]};
      end
      if (ctrl_hit) rd_d = ctrl_rd;
    end
  end

  always_comb begin
    sub_d       = sub_q + 1'b1;
    phase_d     = phase_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (sub_q == SUB_W'(SUB_CNT - 1)) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
    end
    if (blink_cnt_q == BLINK_W'(BLINK_CNT - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (res) begin
      sub_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      rd_q        <= '0;
    end else begin
      sub_q       <= sub_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      rd_q        <= rd_d;
    end
  end

  logic [7:0]         cur_digit, pattern;
  logic [SEG_G:SEG_A] hex_seg;
  logic               lit;

  assign cur_digit = digit_q[idx_q];

  seg_hex_decode u_hex (
    .val_i (cur_digit[3:0]),
    .seg_o (hex_seg)
  );

  assign pattern  = hex_q ? {cur_digit[SEG_DP], hex_seg} : cur_digit;
  assign lit      = en_q && (phase_q <= bright_q) && !(blink_q && mask_q[idx_q]);
  assign seg_sel  = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  assign seg_data = lit ? ~pattern : 8'hFF;
  assign dataOut  = rd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed sequences, a bus-op vector
// table and randomized traffic against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int          N        = 4;
  localparam int          CLK_MHZ  = 1;
  localparam int          SCAN_F   = 62500;
  localparam int          BLINK_HZ = 31250;
  localparam logic [31:0] BASE     = 32'h0000_0010;
  localparam logic [31:0] CTRL_A   = BASE + 32'h40;
  localparam int          SUB      = (CLK_MHZ * 1000000 / SCAN_F) / 16;
  localparam int          SLOT     = 16 * SUB;
  localparam int          BLINK    = CLK_MHZ * 1000000 / (2 * BLINK_HZ);

  logic          clk = 1'b0;
  logic          res, re, we;
  logic [31:0]   addr, dataIn, dataOut;
  logic [7:0]    seg_data;
  logic [N-1:0]  seg_sel;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .CLK        (CLK_MHZ),
    .SCAN_F     (SCAN_F),
    .BLINK_HZ   (BLINK_HZ),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .res      (res),
    .re       (re),
    .we       (we),
    .addr     (addr),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .seg_data (seg_data),
    .seg_sel  (seg_sel)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus edges elapsed since reset.
  logic [6:0]   hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]   m_dig [N];
  logic         m_en, m_hex;
  logic [3:0]   m_bright;
  logic [N-1:0] m_mask;
  logic [31:0]  m_rd;
  int           m_t;

  function automatic int m_phase();
    return (m_t / SUB) % 16;
  endfunction
  function automatic int m_idx();
    return (m_t / SLOT) % N;
  endfunction
  function automatic int m_blink();
    return (m_t / BLINK) % 2;
  endfunction

  // -1: unmapped, N: CTRL, otherwise digit number.
  function automatic int reg_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00) return -1;
    if (off == 32'h40) return N;
    if (off < 32'(4 * N)) return int'(off) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input int k);
    logic [31:0] v;
    v = '0;
    if (k == N) begin
      v[0]      = m_en;
      v[1]      = m_hex;
      v[7:4]    = m_bright;
      v[16 +: N] = m_mask;
    end else if (k >= 0) begin
      v[7:0] = m_dig[k];
    end
    return v;
  endfunction

  task automatic model_step(input bit r, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
    int k;
    k = reg_index(a);
    if (r) begin
      for (int i = 0; i < N; i++) m_dig[i] = '0;
      m_en = 1'b1; m_hex = 1'b0; m_bright = 4'hF; m_mask = '0; m_rd = '0; m_t = 0;
    end else begin
      m_rd = rd ? m_read(k) : 32'h0;
      if (wr && k == N) begin
        m_en = d[0]; m_hex = d[1]; m_bright = d[7:4]; m_mask = d[16 +: N];
      end else if (wr && k >= 0) begin
        m_dig[k] = d[7:0];
      end
      m_t++;
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs at negedge.
  task automatic cycle(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    logic [N-1:0] es;
    logic [7:0]   ed, dv, pat;
    logic         lit;
    int           ix;
    res = r; re = rd; we = wr; addr = a; dataIn = d;
    model_step(r, rd, wr, a, d);
    @(posedge clk);
    @(negedge clk);
    ix  = m_idx();
    dv  = m_dig[ix];
    pat = m_hex ? {dv[7], hex_ref[dv[3:0]]} : dv;
    lit = m_en && (m_phase() <= int'(m_bright)) && !(m_blink() == 1 && m_mask[ix]);
    es  = '1;
    if (lit) es[ix] = 1'b0;
    ed  = lit ? ~pat : 8'hFF;
    check("seg_sel", 32'(seg_sel), 32'(es));
    check("seg_data", 32'(seg_data), 32'(ed));
    check("dataOut", dataOut, m_rd);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d);
  endtask
  task automatic rdc(input logic [31:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wait_slot(input int ix, input int ph);
    int n;
    n = 0;
    while (!(m_idx() == ix && m_phase() == ph) && n < 400) begin
      idle();
      n++;
    end
    check("wait_slot_bound", 32'(n >= 400), 32'h0);
  endtask

  task automatic count_lit(output int c);
    c = int'(seg_sel != '1);
    repeat (15) begin
      idle();
      c += int'(seg_sel != '1);
    end
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.exp_rd = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] sel_seq [5];
    int         c;
    sel_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    add(1, 0, 32'h18, 32'h5B,       32'h0);
    add(0, 1, 32'h18, 32'h0,        32'h5B);
    add(0, 1, 32'h50, 32'h0,        32'hF1);
    add(1, 0, 32'h50, 32'h3,        32'h0);
    add(1, 0, 32'h14, 32'h87,       32'h0);
    add(0, 1, 32'h14, 32'h0,        32'h87);
    add(0, 1, 32'h50, 32'h0,        32'h3);
    add(1, 1, 32'h14, 32'h12,       32'h87);
    add(0, 1, 32'h14, 32'h0,        32'h12);
    add(1, 0, 32'h50, 32'hFFFFFF0F, 32'h0);
    add(0, 1, 32'h50, 32'h0,        32'h000F0003);
    add(1, 0, 32'h12, 32'hFF,       32'h0);
    add(0, 1, 32'h10, 32'h0,        32'h0);
    add(0, 1, 32'h12, 32'h0,        32'h0);
    add(0, 1, 32'h20, 32'h0,        32'h0);
    add(0, 1, 32'h0C, 32'h0,        32'h0);
    add(0, 1, 32'h54, 32'h0,        32'h0);
    add(1, 0, 32'h1C, 32'hA5,       32'h0);
    add(0, 1, 32'h1C, 32'h0,        32'hA5);
    add(0, 0, 32'h1C, 32'h0,        32'h0);
    add(1, 0, 32'h20, 32'h77,       32'h0);
    add(1, 1, 32'h50, 32'h31,       32'h000F0003);
    add(0, 1, 32'h50, 32'h0,        32'h31);

    // Reset state and free-running scan order.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_sel", 32'(seg_sel), 32'hE);
    check("rst_data", 32'(seg_data), 32'hFF);
    check("rst_dout", dataOut, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      idle();
      if (k % 16 == 0) check("scan_seq", 32'(seg_sel), 32'(sel_seq[k / 16]));
    end

    // Raw digit write, readback and display.
    wr(BASE + 32'h8, 32'h5B);
    rdc(BASE + 32'h8);
    check("dig2_read", dataOut, 32'h5B);
    wait_slot(2, 0);
    check("dig2_raw", 32'(seg_data), 32'hA4);

    // Hex mode with dp; bright=0 lights only the first sub-phase.
    wr(CTRL_A, 32'h3);
    wr(BASE + 32'h4, 32'h87);
    wait_slot(1, 0);
    check("dig1_hex", 32'(seg_data), 32'h78);
    check("dig1_sel", 32'(seg_sel), 32'hD);
    idle();
    check("bright0_dark", 32'(seg_sel), 32'hF);

    // Brightness 3 gives four lit cycles per slot.
    wr(CTRL_A, 32'h31);
    wait_slot(0, 0);
    count_lit(c);
    check("bright3_d0", 32'(c), 32'd4);
    wait_slot(3, 0);
    count_lit(c);
    check("bright3_d3", 32'(c), 32'd4);

    // Blink mask, CTRL readback, misaligned write ignored.
    wr(CTRL_A, 32'h000300F1);
    rdc(CTRL_A);
    check("ctrl_mask_read", dataOut, 32'h000300F1);
    wr(BASE + 32'h2, 32'hFF);
    rdc(BASE);
    check("misaligned_wr", dataOut, 32'h0);
    wait_slot(1, 0);
    count_lit(c);
    check("blink_d1_dark", 32'(c), 32'd0);
    wait_slot(2, 0);
    count_lit(c);
    check("unmasked_d2_lit", 32'(c), 32'd16);

    // Reset mid-slot on digit 3.
    wait_slot(3, 5);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("midrst_sel", 32'(seg_sel), 32'hE);
    check("midrst_dout", dataOut, 32'h0);
    for (int i = 0; i < N; i++) begin
      rdc(BASE + 32'(4 * i));
      check("midrst_digit", dataOut, 32'h0);
    end
    rdc(CTRL_A);
    check("midrst_ctrl", dataOut, 32'hF1);

    // Table of bus operations from a fresh reset.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d", i), dataOut, vecs[i].exp_rd);
    end

    // Randomized traffic with occasional resets.
    repeat (800) begin
      logic [31:0] a;
      int          u;
      u = $urandom_range(0, 7);
      case (u)
        0, 1, 2, 3: a = BASE + 32'(4 * u);
        4:          a = CTRL_A;
        5:          a = BASE + 32'(4 * $urandom_range(N, 15));
        6:          a = BASE + 32'(4 * $urandom_range(0, N)) + 32'($urandom_range(1, 3));
        default:    a = $urandom;
      endcase
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
